// File: rtl/fp_cmp_sched96.sv
// Round-robin scheduler sharing one external combinational FP96 compare unit among NREQ
// requesters through a two-stage operand/result pipeline with sticky NaN flags and an op count.
module fp_cmp_sched96 #(
    parameter int   NREQ = 4,
    parameter int   TAGW = 4,
    localparam int  IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 clr_flags,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*96-1:0]   req_a,
    input  logic [NREQ*96-1:0]   req_b,
    input  logic [NREQ*TAGW-1:0] req_tag,
    output logic [95:0]          cmp_a,
    output logic [95:0]          cmp_b,
    input  logic [15:0]          cmp_o,
    input  logic                 cmp_nan,
    input  logic                 cmp_snan,
    input  logic                 cmp_inf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [TAGW-1:0]      rsp_tag,
    output logic [15:0]          rsp_o,
    output logic                 rsp_nan,
    output logic                 rsp_snan,
    output logic                 rsp_inf,
    output logic                 sticky_nan,
    output logic                 sticky_snan,
    output logic [31:0]          op_count
);

    logic            s1_v_r;
    logic [95:0]     s1_a_r;
    logic [95:0]     s1_b_r;
    logic [IDW-1:0]  s1_id_r;
    logic [TAGW-1:0] s1_tag_r;
    logic            s2_v_r;
    logic [IDW-1:0]  s2_id_r;
    logic [TAGW-1:0] s2_tag_r;
    logic [15:0]     s2_o_r;
    logic            s2_nan_r;
    logic            s2_snan_r;
    logic            s2_inf_r;
    logic [IDW-1:0]  ptr_r;
    logic            sticky_nan_r;
    logic            sticky_snan_r;
    logic [31:0]     op_count_r;

    logic            adv1_s;
    logic            adv2_s;
    logic            acc_s;
    logic            issue_s;
    logic            grant_v_s;
    logic [IDW-1:0]  grant_id_s;
    logic [NREQ-1:0] req_ready_s;

    // Requester index base+step modulo NREQ; base < NREQ and step <= NREQ so one subtract suffices.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned step);
        logic [IDW:0] sum;
        sum = {1'b0, base} + (IDW+1)'(step);
        sum = (sum >= (IDW+1)'(NREQ)) ? (sum - (IDW+1)'(NREQ)) : sum;
        return sum[IDW-1:0];
    endfunction

    assign adv2_s  = s1_v_r & (~s2_v_r | rsp_ready);
    assign adv1_s  = ~s1_v_r | adv2_s;
    assign acc_s   = s2_v_r & rsp_ready;
    assign issue_s = rst_n & ~flush & adv1_s & grant_v_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_v_s  = 1'b0;
        grant_id_s = ptr_r;
        for (int k = 1; k <= NREQ; k++) begin
            grant_id_s = (!grant_v_s && req_valid[rr_idx(ptr_r, k)]) ? rr_idx(ptr_r, k) : grant_id_s;
            grant_v_s  = grant_v_s | req_valid[rr_idx(ptr_r, k)];
        end
    end

    // One-hot ready for the granted requester, only in a cycle that actually issues.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if (issue_s) begin
            req_ready_s[grant_id_s] = 1'b1;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    // Stage 1: operand register feeding the compare unit, plus arbiter pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_a_r   <= 96'd0;
            s1_b_r   <= 96'd0;
            s1_id_r  <= {IDW{1'b0}};
            s1_tag_r <= {TAGW{1'b0}};
            ptr_r    <= IDW'(NREQ - 1);
        end else if (flush) begin
            s1_v_r <= 1'b0;
        end else if (adv1_s) begin
            s1_v_r <= grant_v_s;
            if (issue_s) begin
                s1_a_r   <= req_a[96*grant_id_s +: 96];
                s1_b_r   <= req_b[96*grant_id_s +: 96];
                s1_id_r  <= grant_id_s;
                s1_tag_r <= req_tag[TAGW*grant_id_s +: TAGW];
                ptr_r    <= grant_id_s;
            end
        end
    end

    // Stage 2: result register; holds steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r    <= 1'b0;
            s2_id_r   <= {IDW{1'b0}};
            s2_tag_r  <= {TAGW{1'b0}};
            s2_o_r    <= 16'd0;
            s2_nan_r  <= 1'b0;
            s2_snan_r <= 1'b0;
            s2_inf_r  <= 1'b0;
        end else if (flush) begin
            s2_v_r <= 1'b0;
        end else if (adv2_s) begin
            s2_v_r    <= 1'b1;
            s2_id_r   <= s1_id_r;
            s2_tag_r  <= s1_tag_r;
            s2_o_r    <= cmp_o;
            s2_nan_r  <= cmp_nan;
            s2_snan_r <= cmp_snan;
            s2_inf_r  <= cmp_inf;
        end else if (rsp_ready) begin
            s2_v_r <= 1'b0;
        end
    end

    // Sticky flags and accepted-response counter; a flush does not cancel an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_nan_r  <= 1'b0;
            sticky_snan_r <= 1'b0;
            op_count_r    <= 32'd0;
        end else begin
            sticky_nan_r  <= (sticky_nan_r  & ~clr_flags) | (acc_s & s2_nan_r);
            sticky_snan_r <= (sticky_snan_r & ~clr_flags) | (acc_s & s2_snan_r);
            op_count_r    <= op_count_r + {31'd0, acc_s};
        end
    end

    assign req_ready   = req_ready_s;
    assign cmp_a       = s1_a_r;
    assign cmp_b       = s1_b_r;
    assign rsp_valid   = s2_v_r;
    assign rsp_id      = s2_id_r;
    assign rsp_tag     = s2_tag_r;
    assign rsp_o       = s2_o_r;
    assign rsp_nan     = s2_nan_r;
    assign rsp_snan    = s2_snan_r;
    assign rsp_inf     = s2_inf_r;
    assign sticky_nan  = sticky_nan_r;
    assign sticky_snan = sticky_snan_r;
    assign op_count    = op_count_r;

endmodule
